// File: rtl/boot_rom_pkg.sv
// Shared types and constants for the boot ROM bus adapter.
// ROM_ADDR_WIDTH (macro) overrides the default ROM byte-address width.
`ifndef ROM_ADDR_WIDTH
`define ROM_ADDR_WIDTH 12
`endif

package boot_rom_pkg;

  localparam int unsigned BOOT_ROM_AW = `ROM_ADDR_WIDTH;

  localparam logic [31:0] BOOT_ROM_BASE = 32'h1A00_0000;
  localparam logic [31:0] ROM_ERR_RDATA = 32'h0;

  typedef struct packed {
    logic        err;
    logic [31:0] rdata;
  } resp_t;

  function automatic logic in_rom_window(input logic [31:0] addr,
                                         input logic [31:0] base,
                                         input int unsigned aw);
    return (addr >> aw) == (base >> aw);
  endfunction

endpackage

// File: rtl/boot_rom_resp_fifo.sv
// Synchronous response FIFO; head entry is presented combinationally.
module boot_rom_resp_fifo
  import boot_rom_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter type         T     = resp_t
) (
  input  logic clk,
  input  logic rst,
  input  logic i_push,
  input  T     i_data,
  input  logic i_pop,
  output logic o_full,
  output logic o_empty,
  output T     o_head
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  T                r_mem [DEPTH];
  logic [PW-1:0]   r_wptr;
  logic [PW-1:0]   r_rptr;
  logic [CW-1:0]   r_count;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_wptr <= ptr_inc(r_wptr);
      if (i_pop)  r_rptr <= ptr_inc(r_rptr);
      r_count <= r_count + CW'(i_push) - CW'(i_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wptr] <= i_data;
  end

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == CW'(DEPTH));
  assign o_head  = r_mem[r_rptr];

endmodule

// File: rtl/boot_rom_bus_adapter.sv
// req/gnt/rvalid slave adapter in front of the boot ROM, with error responses.
// BOOT_ROM_LOCK_EN (macro) enables the sticky post-boot lock.
module boot_rom_bus_adapter
  import boot_rom_pkg::*;
#(
  parameter int unsigned ROM_ADDR_WIDTH = BOOT_ROM_AW,
  parameter logic [31:0] BASE_ADDR      = BOOT_ROM_BASE,
  parameter int unsigned RESP_DEPTH     = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req_i,
  output logic                      gnt_o,
  input  logic [31:0]               addr_i,
  input  logic                      we_i,
  input  logic [3:0]                be_i,
  input  logic [31:0]               wdata_i,
  output logic                      rvalid_o,
  input  logic                      rready_i,
  output logic [31:0]               rdata_o,
  output logic                      err_o,
  output logic                      rom_en_o,
  output logic [ROM_ADDR_WIDTH-1:0] rom_addr_o,
  input  logic [31:0]               rom_rdata_i,
  input  logic                      lock_i
);

  localparam int unsigned CW = $clog2(RESP_DEPTH + 1);

  logic [CW-1:0] r_cnt;
  logic          r_inflight;
  logic          r_inflight_err;
  logic          w_accept;
  logic          w_legal;
  logic          w_locked;
  logic          w_valid;
  logic          w_retire;
  logic          w_push;
  logic          w_pop;
  logic          w_fifo_full;
  logic          w_fifo_empty;
  resp_t         w_new_resp;
  resp_t         w_head;
  resp_t         w_out;
  logic          w_unused_ok;

`ifdef BOOT_ROM_LOCK_EN
  logic r_lock;

  always_ff @(posedge clk) begin
    if (rst)         r_lock <= 1'b0;
    else if (lock_i) r_lock <= 1'b1;
  end

  assign w_locked    = r_lock;
  assign w_unused_ok = ^{be_i, wdata_i, w_fifo_full};
`else
  assign w_locked    = 1'b0;
  assign w_unused_ok = ^{be_i, wdata_i, w_fifo_full, lock_i};
`endif

  assign gnt_o      = req_i & ~rst & (r_cnt < CW'(RESP_DEPTH));
  assign w_accept   = gnt_o;
  assign w_legal    = ~we_i & ~w_locked & in_rom_window(addr_i, BASE_ADDR, ROM_ADDR_WIDTH);
  assign rom_en_o   = w_accept & w_legal;
  assign rom_addr_o = addr_i[ROM_ADDR_WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt          <= '0;
      r_inflight     <= 1'b0;
      r_inflight_err <= 1'b0;
    end else begin
      r_cnt          <= r_cnt + CW'(w_accept) - CW'(w_retire);
      r_inflight     <= w_accept;
      r_inflight_err <= ~w_legal;
    end
  end

  assign w_new_resp.err   = r_inflight_err;
  assign w_new_resp.rdata = r_inflight_err ? ROM_ERR_RDATA : rom_rdata_i;

  // Empty FIFO lets the ROM word fall straight through; otherwise the head
  // owns the outputs and the arriving word queues behind it.
  assign w_out    = w_fifo_empty ? w_new_resp : w_head;
  assign w_valid  = ~rst & (~w_fifo_empty | r_inflight);
  assign w_retire = w_valid & rready_i;
  assign w_push   = ~rst & r_inflight & ~(w_fifo_empty & rready_i);
  assign w_pop    = ~rst & ~w_fifo_empty & rready_i;

  assign rvalid_o = w_valid;
  assign rdata_o  = w_valid ? w_out.rdata : '0;
  assign err_o    = w_valid & w_out.err;

  boot_rom_resp_fifo #(
    .DEPTH (RESP_DEPTH),
    .T     (resp_t)
  ) u_resp_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  (w_new_resp),
    .i_pop   (w_pop),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_head  (w_head)
  );

endmodule

// File: tb/tb_boot_rom_bus_adapter.sv
// Directed bench for boot_rom_bus_adapter (default: 12-bit window, depth 2).
module tb_boot_rom_bus_adapter;

  localparam logic [31:0] BASE = 32'h1A00_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic        gnt;
  logic [31:0] addr = '0;
  logic        we = 1'b0;
  logic [3:0]  be = 4'hF;
  logic [31:0] wdata = '0;
  logic        rvalid;
  logic        rready = 1'b1;
  logic [31:0] rdata;
  logic        err;
  logic        rom_en;
  logic [11:0] rom_addr;
  logic [31:0] rom_rdata = '0;
  logic        lock = 1'b0;

  int n_cmp = 0;
  int n_err = 0;

  boot_rom_bus_adapter #(
    .ROM_ADDR_WIDTH (12),
    .BASE_ADDR      (BASE),
    .RESP_DEPTH     (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_i       (req),
    .gnt_o       (gnt),
    .addr_i      (addr),
    .we_i        (we),
    .be_i        (be),
    .wdata_i     (wdata),
    .rvalid_o    (rvalid),
    .rready_i    (rready),
    .rdata_o     (rdata),
    .err_o       (err),
    .rom_en_o    (rom_en),
    .rom_addr_o  (rom_addr),
    .rom_rdata_i (rom_rdata),
    .lock_i      (lock)
  );

  always #5 clk = ~clk;

  // ROM model: word-indexed, returns B007_0000 | word byte offset one cycle later.
  always @(posedge clk) begin
    if (rom_en) rom_rdata <= 32'hB007_0000 | {20'h0, rom_addr[11:2], 2'b00};
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic w, input logic [31:0] a, input logic rdy);
    req    = r;
    we     = w;
    addr   = a;
    rready = rdy;
    #2;
  endtask

  initial begin
    // Reset state
    next();
    drive(1, 0, BASE, 1);
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_rvalid", 32'(rvalid), 0);
    chk("rst_rom_en", 32'(rom_en), 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_err", 32'(err), 0);
    next();
    rst = 1'b0;

    // 1: single read at BASE+0x10
    drive(1, 0, BASE + 32'h10, 1);
    chk("t1_gnt", 32'(gnt), 1);
    chk("t1_rom_en", 32'(rom_en), 1);
    chk("t1_rom_addr", 32'(rom_addr), 32'h10);
    chk("t1_rvalid_early", 32'(rvalid), 0);
    next();
    drive(0, 0, 0, 1);
    chk("t1_rvalid", 32'(rvalid), 1);
    chk("t1_rdata", rdata, 32'hB007_0010);
    chk("t1_err", 32'(err), 0);
    next();

    // 2: four back-to-back reads
    for (int i = 0; i < 5; i++) begin
      if (i < 4) drive(1, 0, BASE + 32'(i * 4), 1);
      else       drive(0, 0, 0, 1);
      if (i < 4) chk("t2_gnt", 32'(gnt), 1);
      if (i > 0) begin
        chk("t2_rvalid", 32'(rvalid), 1);
        chk("t2_rdata", rdata, 32'hB007_0000 + 32'((i - 1) * 4));
      end
      next();
    end
    drive(0, 0, 0, 1);
    chk("t2_idle", 32'(rvalid), 0);

    // 3: rready low for 5 cycles, depth 2
    drive(1, 0, BASE + 32'h20, 0);
    chk("t3_gntA", 32'(gnt), 1);
    chk("t3_rvA", 32'(rvalid), 0);
    next();
    drive(1, 0, BASE + 32'h24, 0);
    chk("t3_gntB", 32'(gnt), 1);
    chk("t3_rdA0", rdata, 32'hB007_0020);
    next();
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, BASE + 32'h28, 0);
      chk("t3_gnt_full", 32'(gnt), 0);
      chk("t3_rvalid_hold", 32'(rvalid), 1);
      chk("t3_rdata_hold", rdata, 32'hB007_0020);
      next();
    end
    drive(1, 0, BASE + 32'h28, 1);
    chk("t3_gnt_drain0", 32'(gnt), 0);
    chk("t3_rdA", rdata, 32'hB007_0020);
    next();
    drive(1, 0, BASE + 32'h28, 1);
    chk("t3_gnt_resume", 32'(gnt), 1);
    chk("t3_rdB", rdata, 32'hB007_0024);
    next();
    drive(0, 0, 0, 1);
    chk("t3_rvC", 32'(rvalid), 1);
    chk("t3_rdC", rdata, 32'hB007_0028);
    next();
    drive(0, 0, 0, 1);
    chk("t3_idle", 32'(rvalid), 0);

    // 4: write, out-of-range read, misaligned read
    drive(1, 1, BASE, 1);
    chk("t4_wr_gnt", 32'(gnt), 1);
    chk("t4_wr_rom_en", 32'(rom_en), 0);
    next();
    drive(1, 0, BASE + 32'h1000, 1);
    chk("t4_oor_gnt", 32'(gnt), 1);
    chk("t4_oor_rom_en", 32'(rom_en), 0);
    chk("t4_wr_err", 32'(err), 1);
    chk("t4_wr_rdata", rdata, 0);
    next();
    drive(1, 0, BASE + 32'h31, 1);
    chk("t4_mis_rom_en", 32'(rom_en), 1);
    chk("t4_mis_rom_addr", 32'(rom_addr), 32'h31);
    chk("t4_oor_rvalid", 32'(rvalid), 1);
    chk("t4_oor_err", 32'(err), 1);
    chk("t4_oor_rdata", rdata, 0);
    next();
    drive(0, 0, 0, 1);
    chk("t4_mis_err", 32'(err), 0);
    chk("t4_mis_rdata", rdata, 32'hB007_0030);
    next();

    // 5: reset with one response queued and one in flight
    drive(1, 0, BASE + 32'h40, 0);
    next();
    drive(1, 0, BASE + 32'h44, 0);
    next();
    rst = 1'b1;
    drive(1, 0, BASE + 32'h48, 0);
    chk("t5_rst_gnt", 32'(gnt), 0);
    chk("t5_rst_rvalid", 32'(rvalid), 0);
    chk("t5_rst_rdata", rdata, 0);
    next();
    rst = 1'b0;
    drive(0, 0, 0, 1);
    chk("t5_no_stale", 32'(rvalid), 0);
    next();
    drive(1, 0, BASE + 32'h50, 0);
    chk("t5_gnt0", 32'(gnt), 1);
    next();
    drive(1, 0, BASE + 32'h54, 0);
    chk("t5_gnt1", 32'(gnt), 1);
    chk("t5_rd50_hold", rdata, 32'hB007_0050);
    next();
    drive(0, 0, 0, 1);
    chk("t5_rd50", rdata, 32'hB007_0050);
    next();
    drive(0, 0, 0, 1);
    chk("t5_rd54", rdata, 32'hB007_0054);
    next();
    drive(0, 0, 0, 1);
    chk("t5_idle", 32'(rvalid), 0);

    // 6: lock behaviour
    lock = 1'b1;
    drive(1, 0, BASE + 32'h60, 1);
    chk("t6_gnt_pre", 32'(gnt), 1);
    chk("t6_rom_en_pre", 32'(rom_en), 1);
    next();
    lock = 1'b0;
    drive(1, 0, BASE + 32'h64, 1);
    chk("t6_pending_err", 32'(err), 0);
    chk("t6_pending_rdata", rdata, 32'hB007_0060);
`ifdef BOOT_ROM_LOCK_EN
    chk("t6_locked_rom_en", 32'(rom_en), 0);
    next();
    drive(0, 0, 0, 1);
    chk("t6_locked_err", 32'(err), 1);
    chk("t6_locked_rdata", rdata, 0);
    next();
    rst = 1'b1;
    next();
    rst = 1'b0;
    drive(1, 0, BASE + 32'h68, 1);
    chk("t6_unlock_rom_en", 32'(rom_en), 1);
    next();
    drive(0, 0, 0, 1);
    chk("t6_unlock_err", 32'(err), 0);
    chk("t6_unlock_rdata", rdata, 32'hB007_0068);
`else
    chk("t6_nolock_rom_en", 32'(rom_en), 1);
    next();
    drive(0, 0, 0, 1);
    chk("t6_nolock_err", 32'(err), 0);
    chk("t6_nolock_rdata", rdata, 32'hB007_0064);
`endif
    next();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
